divider_nonrestoring: RTL
=========================

Name: divider_nonrestoring

Overview:
- Sequential signed (two's-complement) integer divider. Uses non-restoring division with shift-left and add/subtract, one quotient bit per clock.
- Inverse companion to the team's Booth multiplier: same load/done handshake and same operand width parameterisation.
- Sits beside the multiplier in the arithmetic datapath.
- Quotient truncates toward zero. Remainder takes the sign of the dividend.

Parameters:
- width, 8, operand width in bits for dividend, divisor, quotient and remainder.
- no, 4, iteration counter width; must satisfy 2**no > width.

Ports:
- clock, input, 1, single rising-edge clock.
- clear_n, input, 1, synchronous active-low reset, sampled on rising edge of clock.
- load, input, 1, start pulse; operands captured on the edge where load=1.
- dividend, input, width, signed dividend.
- divisor, input, width, signed divisor.
- quotient, output reg, width, signed quotient.
- remainder, output reg, width, signed remainder.
- done, output reg, 1, result valid; stays high until next load or reset.
- div_by_zero, output reg, 1, set with done when divisor==0.
- overflow, output reg, 1, set with done for (-2**(width-1)) / (-1).

Behaviour:
- Reset: on a rising edge with clear_n=0, state=IDLE and count=0. quotient, remainder, done, div_by_zero and overflow all go to 0. clear_n has priority over load.
- States: IDLE, RUN, FIX, DONE.
- Load (any state, clear_n=1, load=1):
  - Capture sign_q = dividend[msb]^divisor[msb] and sign_r = dividend[msb].
  - Capture magnitudes |dividend| and |divisor| as width-bit unsigned values (|-2**(width-1)| = 2**(width-1)).
  - Set R (width+1-bit signed) = 0, Q = |dividend|, count = 0.
  - Clear done, div_by_zero and overflow.
  - Next state is FIX with a zero flag if divisor==0; otherwise RUN.
  - Load during RUN or FIX aborts the current operation and restarts.
- RUN, one iteration per edge:
  - If R>=0: R = {R,Q[msb]} - D.
  - Else: R = {R,Q[msb]} + D.
  - Then Q = {Q[width-2:0], ~R_new[msb]} and count = count+1.
  - After the width-th iteration (count==width-1 at that edge), go to FIX.
- FIX, one edge:
  - If the zero flag is set: quotient = all ones, remainder = dividend (raw), div_by_zero = 1.
  - Otherwise: if R<0, R = R + D.
  - quotient = sign_q ? -Q : Q.
  - remainder = sign_r ? -R[width-1:0] : R[width-1:0].
  - overflow = 1 iff dividend = -2**(width-1) and divisor = -1. quotient wraps to 0x80..0 and remainder = 0.
  - done = 1. Next state is DONE.
- DONE/IDLE: outputs hold. Only load or reset changes them.
- quotient and remainder hold their previous values through RUN. They update only on the FIX edge.
- Latency: with load sampled at edge L, done rises at edge L+width+1 (L+9 for width=8). For divide-by-zero, done rises at edge L+1.
- load held high continuously restarts every cycle, so done never rises.
- Internal add/sub is width+1 bits wide; no carry is lost.

Test Plan:
1. width=8. dividend=100, divisor=7, one-cycle load -> done at L+9; quotient=0x0E, remainder=0x02, flags 0. done stays high 5+ idle cycles with outputs stable.
2. Sign cases:
   - -100/7 -> quotient=0xF2, remainder=0xFE.
   - 100/-7 -> quotient=0xF2, remainder=0x02.
   - -100/-7 -> quotient=0x0E, remainder=0xFE.
   - 0/5 -> quotient=0x00, remainder=0x00.
3. Divide by zero: dividend=0x55, divisor=0 -> done at L+1; quotient=0xFF, remainder=0x55, div_by_zero=1, overflow=0.
4. Overflow and extremes:
   - -128/-1 -> quotient=0x80, remainder=0x00, overflow=1.
   - -128/1 -> quotient=0x80, overflow=0.
   - 127/-128 -> quotient=0x00, remainder=0x7F.
5. Abort: load 50/3, then re-load 20/3 four edges later -> single done at L2+9 with quotient=0x06, remainder=0x02. No done for the first operation.
6. Reset mid-run: clear_n=0 for one edge during RUN, with load=1 on the same edge -> next cycle all outputs 0, state IDLE, no done. Reset has priority over load.

Source files
------------

// File: rtl/divider_nonrestoring.sv
// Sequential signed divider using non-restoring shift/add-subtract, one quotient bit per clock.
// Quotient truncates toward zero; remainder takes the sign of the dividend.
module divider_nonrestoring #(
    parameter int width = 8,
    parameter int no    = 4
) (
    input  logic             clock,
    input  logic             clear_n,
    input  logic             load,
    input  logic [width-1:0] dividend,
    input  logic [width-1:0] divisor,
    output logic [width-1:0] quotient,
    output logic [width-1:0] remainder,
    output logic             done,
    output logic             div_by_zero,
    output logic             overflow
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic signed [width:0] r_acc;
    logic [width-1:0]      q_acc;
    logic [width-1:0]      d_mag;
    logic [width-1:0]      dividend_raw;
    logic [no-1:0]         count;
    logic                  sign_q;
    logic                  sign_r;
    logic                  zero_flag;
    logic                  ovf_flag;

    logic [width-1:0]      dividend_mag;
    logic [width-1:0]      divisor_mag;
    logic                  divisor_zero;
    logic                  ovf_case;
    logic signed [width:0] d_ext;
    logic signed [width:0] r_shift;
    logic signed [width:0] r_step;
    logic signed [width:0] r_fixed;
    logic                  last_iter;

    // Magnitudes are width-bit unsigned, so the most negative operand maps cleanly to 2**(width-1).
    always_comb begin
        dividend_mag = dividend[width-1] ? -dividend : dividend;
        divisor_mag  = divisor[width-1]  ? -divisor  : divisor;
        divisor_zero = (divisor == '0);
        ovf_case     = (dividend == {1'b1, {(width-1){1'b0}}}) && (divisor == '1);
        d_ext        = {1'b0, d_mag};
        r_shift      = {r_acc[width-1:0], q_acc[width-1]};
        r_step       = r_acc[width] ? (r_shift + d_ext) : (r_shift - d_ext);
        r_fixed      = r_acc[width] ? (r_acc + d_ext) : r_acc;
        last_iter    = (count == no'(width - 1));
    end

    always_ff @(posedge clock) begin
        if (!clear_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    // A load restarts from any state, including mid-run.
    always_comb begin
        state_next = state;
        if (load) begin
            state_next = divisor_zero ? FIX : RUN;
        end else begin
            case (state)
                RUN:     if (last_iter) state_next = FIX;
                FIX:     state_next = DONE;
                default: state_next = state;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!clear_n) begin
            r_acc        <= '0;
            q_acc        <= '0;
            d_mag        <= '0;
            dividend_raw <= '0;
            count        <= '0;
            sign_q       <= 1'b0;
            sign_r       <= 1'b0;
            zero_flag    <= 1'b0;
            ovf_flag     <= 1'b0;
            quotient     <= '0;
            remainder    <= '0;
            done         <= 1'b0;
            div_by_zero  <= 1'b0;
            overflow     <= 1'b0;
        end else if (load) begin
            r_acc        <= '0;
            q_acc        <= dividend_mag;
            d_mag        <= divisor_mag;
            dividend_raw <= dividend;
            count        <= '0;
            sign_q       <= dividend[width-1] ^ divisor[width-1];
            sign_r       <= dividend[width-1];
            zero_flag    <= divisor_zero;
            ovf_flag     <= ovf_case;
            done         <= 1'b0;
            div_by_zero  <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    r_acc <= r_step;
                    q_acc <= {q_acc[width-2:0], ~r_step[width]};
                    count <= count + no'(1);
                end
                // The final correction restores a negative partial remainder before sign fix-up.
                FIX: begin
                    done <= 1'b1;
                    if (zero_flag) begin
                        quotient    <= '1;
                        remainder   <= dividend_raw;
                        div_by_zero <= 1'b1;
                    end else begin
                        r_acc     <= r_fixed;
                        quotient  <= sign_q ? -q_acc : q_acc;
                        remainder <= sign_r ? -r_fixed[width-1:0] : r_fixed[width-1:0];
                        overflow  <= ovf_flag;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
